serial_adder_resp: RTL

Bit-serial full-adder responder: the response side of the adder stimulus interface that drives a_in/b_in/c_in and monitors sum_out/c_out. It accepts two LSB-first operand streams plus an initial carry, produces one registered sum bit per accepted bit pair, and assembles a WIDTH-bit parallel sum word with a final carry. It sits between a bit-level stimulus source and any word-level checker or consumer.

---
 rtl/serial_adder_resp.sv | 99 +++++++++
 1 files changed

// File: rtl/serial_adder_resp.sv
// Bit-serial full-adder responder: takes two LSB-first operand streams plus an
// initial carry, emits a registered sum bit per accepted pair and a word result.
module serial_adder_resp #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             c_in,
  input  logic             bit_valid,
  input  logic             a_in,
  input  logic             b_in,
  output logic             busy,
  output logic             sum_out,
  output logic [WIDTH-1:0] sum_word,
  output logic             c_out,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(WIDTH - 1);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_RUN  = 2'd1;
  localparam logic [1:0] S_DONE = 2'd2;

  function automatic logic fa_sum(input logic a, input logic b, input logic c);
    return a ^ b ^ c;
  endfunction

  function automatic logic fa_carry(input logic a, input logic b, input logic c);
    return (a & b) | (c & (a ^ b));
  endfunction

  logic [1:0]       r_state;
  logic             r_carry;
  logic [CNT_W-1:0] r_cnt;
  logic [WIDTH-1:0] r_shreg;
  logic [WIDTH-1:0] r_sum_word;
  logic             r_sum_out;
  logic             r_c_out;

  logic             w_s;
  logic             w_c;
  logic [WIDTH-1:0] w_shreg_nxt;

  // Bit k lands at position k, which matches the right-shifting assembly once all WIDTH bits are in.
  always_comb begin
    w_s                = fa_sum(a_in, b_in, r_carry);
    w_c                = fa_carry(a_in, b_in, r_carry);
    w_shreg_nxt        = r_shreg;
    w_shreg_nxt[r_cnt] = w_s;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state    <= S_IDLE;
      r_carry    <= 1'b0;
      r_cnt      <= '0;
      r_shreg    <= '0;
      r_sum_word <= '0;
      r_sum_out  <= 1'b0;
      r_c_out    <= 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (start) begin
            r_carry <= c_in;
            r_cnt   <= '0;
            r_shreg <= '0;
            r_state <= S_RUN;
          end
        end
        S_RUN: begin
          if (bit_valid) begin
            r_carry   <= w_c;
            r_sum_out <= w_s;
            r_shreg   <= w_shreg_nxt;
            r_cnt     <= r_cnt + CNT_W'(1);
            if (r_cnt == LAST_CNT) begin
              r_sum_word <= w_shreg_nxt;
              r_c_out    <= w_c;
              r_state    <= S_DONE;
            end
          end
        end
        S_DONE: r_state <= S_IDLE;
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign busy     = (r_state != S_IDLE);
  assign done     = (r_state == S_DONE);
  assign sum_out  = r_sum_out;
  assign sum_word = r_sum_word;
  assign c_out    = r_c_out;

endmodule
